neuron_tdm_scheduler: RTL and testbench
=======================================

// Module: neuron_tdm_scheduler
// PURPOSE
//  Time-division scheduler that shares one Izhikevich neuron core across N virtual neurons.
//  Per frame it snapshots the N input currents and visits each neuron index 0..N-1 in order.
//  For each index it issues stored (v,u) plus the current to the core, waits for the result, and writes back v/u/spike.
//  Sits between the current-computation logic and the Hebbian learning block; the frame spike vector feeds learning.
// PARAMETERS
//  N          7        number of virtual neurons (2..8)
//  W          16       signed width of current, v, u
//  V_REST     -16640   reset value of every stored v (-65.0 in Q8.8)
//  U_REST     -3328    reset value of every stored u (-13.0 in Q8.8)
//  TIMEOUT    15       max cycles to wait for core_done before a slot is aborted
// PORTS
//  clk            in   1     single clock, rising edge
//  reset          in   1     synchronous, active-high
//  frame_start    in   1     pulse: begin a frame (sampled only in IDLE)
//  current_flat   in   N*W   neuron i current at bits [i*W +: W], signed
//  core_start     out  1     one-cycle pulse: core operands valid
//  core_current   out  W     operand current for the active index
//  core_v         out  W     operand v for the active index
//  core_u         out  W     operand u for the active index
//  core_done      in   1     pulse: core_v_next/core_u_next/core_spike valid
//  core_v_next    in   W     updated v
//  core_u_next    in   W     updated u
//  core_spike     in   1     spike flag for the active index
//  active_idx     out  3     index currently in service
//  busy           out  1     high whenever state != IDLE
//  spikes         out  N     spike vector of the last completed frame
//  spikes_valid   out  1     one-cycle pulse when spikes updates
//  err_overrun    out  1     sticky: frame_start seen while busy
//  err_timeout    out  1     sticky: a slot hit TIMEOUT
// BEHAVIOUR
//  Reset (synchronous): state=IDLE; all v=V_REST, u=U_REST; spikes=0; active_idx=0.
//   Also: core_start=0, spikes_valid=0, busy=0, both err flags=0; core_* operand outputs=0.
//  FSM:
//   IDLE  -> SNAP on frame_start.
//   SNAP  : latch current_flat into the snapshot; clear the frame spike accumulator; idx=0; -> ISSUE.
//   ISSUE : drive operands for idx; core_start=1 for exactly this cycle; clear the wait counter; -> WAIT.
//   WAIT  : on core_done -> WB.
//           Otherwise, when the counter reaches TIMEOUT -> WB_ABORT. Else increment the counter.
//   WB    : store core_v_next/core_u_next to idx; accum[idx]=core_spike; -> NEXT.
//   WB_ABORT : keep the stored v/u; accum[idx]=0; set err_timeout; -> NEXT.
//   NEXT  : if idx==N-1 -> DONE, else idx++ and -> ISSUE.
//   DONE  : spikes<=accum; spikes_valid=1 for one cycle; -> IDLE.
//  Operands hold stable from ISSUE through WAIT; core_done is ignored outside WAIT.
//  A core_done in the same cycle as the TIMEOUT limit is accepted as a normal WB.
//  Frame latency: 3 + sum over slots of (1 + wait_i + 1) cycles, where wait_i >= 1.
//   With core_done arriving 1 cycle after core_start: 3 + 3N = 24 cycles for N=7.
//  Currents are taken only from the SNAP copy; changes to current_flat mid-frame have no effect until the next frame.
//  frame_start while busy: ignored, err_overrun set, frame continues unaffected.
//  Reset asserted mid-frame: aborts immediately and restores all reset values; the partial frame is never published.
//  v/u are passed through bit-exact; no saturation or arithmetic is performed here.
//  active_idx wraps only through DONE/IDLE and never exceeds N-1.
// CONFIGURATION
//  REFRACTORY_EN defined:
//   Each neuron has a 2-bit refractory counter. A stored spike loads REFRAC_FRAMES=3.
//   While the counter is nonzero, that neuron's core_current is forced to 0; the counter decrements once per frame at its WB.
//   The counter resets to 0.
//  REFRACTORY_EN undefined:
//   No counters; core_current always equals the snapshot value.
// TESTING
//  1. reset, then frame_start, core_done 1 cycle after each core_start, core_spike=0
//     -> 7 core_start pulses for active_idx 0..6; core_v=-16640 each time.
//     -> spikes_valid at cycle 24; spikes=7'b0.
//  2. model core returns v_next=v+256 and spike=(idx==2)
//     -> spikes=7'b0000100; the next frame shows core_v=-16384 for every idx.
//  3. change current_flat[0 +: 16] from 1024 to 3072 in the middle of frame 1
//     -> frame 1 issues core_current=1024 for idx 0; frame 2 issues 3072.
//  4. withhold core_done for idx 3 -> WB_ABORT after 15 wait cycles; err_timeout=1; spikes[3]=0.
//     -> idx 3 keeps its old v/u; idx 4..6 still complete.
//  5. frame_start pulsed at cycle 5 of a frame -> err_overrun=1; exactly one spikes_valid; no restart.
//     Separately: reset at cycle 10 -> busy=0 next cycle; spikes=0; stored v=-16640.
//  6. (REFRACTORY_EN) idx 1 spikes in frame 1 -> core_current for idx 1 is 0 in frames 2-4, snapshot value in frame 5.

Source files
------------

// File: rtl/neuron_tdm_scheduler.sv
// Time-division scheduler sharing one Izhikevich core across N virtual neurons.
// Optional per-neuron refractory hold is enabled by defining REFRACTORY_EN.
`timescale 1ns/1ps
module neuron_tdm_scheduler #(
  parameter int N       = 7,
  parameter int W       = 16,
  parameter int V_REST  = -16640,
  parameter int U_REST  = -3328,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                frame_start_i,
  input  logic [N*W-1:0]      current_flat_i,
  output logic                core_start_o,
  output logic signed [W-1:0] core_current_o,
  output logic signed [W-1:0] core_v_o,
  output logic signed [W-1:0] core_u_o,
  input  logic                core_done_i,
  input  logic signed [W-1:0] core_v_next_i,
  input  logic signed [W-1:0] core_u_next_i,
  input  logic                core_spike_i,
  output logic [2:0]          active_idx_o,
  output logic                busy_o,
  output logic [N-1:0]        spikes_o,
  output logic                spikes_valid_o,
  output logic                err_overrun_o,
  output logic                err_timeout_o
);

  // state      | meaning
  // S_IDLE     | waiting for frame_start
  // S_SNAP     | latch currents, clear accumulator, idx=0
  // S_ISSUE    | operands valid, core_start pulse
  // S_WAIT     | waiting for core_done (bounded by TIMEOUT cycles)
  // S_WB       | store core result, then advance idx or finish
  // S_WB_ABORT | keep stored v/u, flag timeout, then advance idx or finish
  // S_DONE     | publish spike vector
  // The index advance is folded into the write-back states so each slot
  // costs ISSUE + wait + 1 cycles.
  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_ISSUE, S_WAIT, S_WB, S_WB_ABORT, S_DONE
  } state_t;

  localparam int         CW   = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST = 3'(N - 1);

  state_t              state_q, state_d;
  logic [2:0]          idx_q;
  logic [CW-1:0]       cnt_q;
  logic signed [W-1:0] v_mem_q [N];
  logic signed [W-1:0] u_mem_q [N];
  logic signed [W-1:0] snap_q  [N];
  logic [N-1:0]        accum_q, spikes_q;
  logic                spikes_valid_q, err_overrun_q, err_timeout_q;
  logic                last_idx, operand_en;
`ifdef REFRACTORY_EN
  logic [1:0]          refrac_q [N];
`endif

  assign last_idx   = (idx_q == LAST);
  assign operand_en = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // cnt_q counts completed wait cycles, so the slot aborts after TIMEOUT of them
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (frame_start_i) state_d = S_SNAP;
      S_SNAP:     state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT;
      S_WAIT: begin
        if (core_done_i)                         state_d = S_WB;
        else if (cnt_q == CW'(TIMEOUT - 1))      state_d = S_WB_ABORT;
      end
      S_WB,
      S_WB_ABORT: state_d = last_idx ? S_DONE : S_ISSUE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q          <= '0;
      cnt_q          <= '0;
      accum_q        <= '0;
      spikes_q       <= '0;
      spikes_valid_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        v_mem_q[i] <= W'(V_REST);
        u_mem_q[i] <= W'(U_REST);
        snap_q[i]  <= '0;
`ifdef REFRACTORY_EN
        refrac_q[i] <= 2'd0;
`endif
      end
    end else begin
      spikes_valid_q <= 1'b0;
      if (frame_start_i && (state_q != S_IDLE)) err_overrun_q <= 1'b1;
      case (state_q)
        S_SNAP: begin
          for (int i = 0; i < N; i++) snap_q[i] <= current_flat_i[i*W +: W];
          accum_q <= '0;
          idx_q   <= '0;
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT:  if (!core_done_i) cnt_q <= cnt_q + CW'(1);
        S_WB: begin
          v_mem_q[idx_q] <= core_v_next_i;
          u_mem_q[idx_q] <= core_u_next_i;
          accum_q[idx_q] <= core_spike_i;
`ifdef REFRACTORY_EN
          if (core_spike_i)                refrac_q[idx_q] <= 2'd3;
          else if (refrac_q[idx_q] != 2'd0) refrac_q[idx_q] <= refrac_q[idx_q] - 2'd1;
`endif
          if (!last_idx) idx_q <= idx_q + 3'd1;
        end
        S_WB_ABORT: begin
          accum_q[idx_q] <= 1'b0;
          err_timeout_q  <= 1'b1;
`ifdef REFRACTORY_EN
          if (refrac_q[idx_q] != 2'd0) refrac_q[idx_q] <= refrac_q[idx_q] - 2'd1;
`endif
          if (!last_idx) idx_q <= idx_q + 3'd1;
        end
        S_DONE: begin
          spikes_q       <= accum_q;
          spikes_valid_q <= 1'b1;
          idx_q          <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operands come straight from storage, so they stay put through WAIT
  always_comb begin
    core_current_o = '0;
    core_v_o       = '0;
    core_u_o       = '0;
    if (operand_en) begin
      core_v_o = v_mem_q[idx_q];
      core_u_o = u_mem_q[idx_q];
`ifdef REFRACTORY_EN
      core_current_o = (refrac_q[idx_q] != 2'd0) ? '0 : snap_q[idx_q];
`else
      core_current_o = snap_q[idx_q];
`endif
    end
  end

  assign core_start_o   = (state_q == S_ISSUE);
  assign busy_o         = (state_q != S_IDLE);
  assign active_idx_o   = idx_q;
  assign spikes_o       = spikes_q;
  assign spikes_valid_o = spikes_valid_q;
  assign err_overrun_o  = err_overrun_q;
  assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Directed table-driven bench for neuron_tdm_scheduler with a behavioural core responder.
`timescale 1ns/1ps
module tb_neuron_tdm_scheduler;
  localparam int N = 7;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                frame_start = 1'b0;
  logic [N*W-1:0]      current_flat = '0;
  logic                core_start;
  logic signed [W-1:0] core_current, core_v, core_u;
  logic                core_done = 1'b0;
  logic signed [W-1:0] core_v_next = '0, core_u_next = '0;
  logic                core_spike = 1'b0;
  logic [2:0]          active_idx;
  logic                busy;
  logic [N-1:0]        spikes;
  logic                spikes_valid, err_overrun, err_timeout;

  always #5 clk = ~clk;

  neuron_tdm_scheduler dut (
    .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start),
    .current_flat_i(current_flat), .core_start_o(core_start),
    .core_current_o(core_current), .core_v_o(core_v), .core_u_o(core_u),
    .core_done_i(core_done), .core_v_next_i(core_v_next), .core_u_next_i(core_u_next),
    .core_spike_i(core_spike), .active_idx_o(active_idx), .busy_o(busy),
    .spikes_o(spikes), .spikes_valid_o(spikes_valid),
    .err_overrun_o(err_overrun), .err_timeout_o(err_timeout)
  );

  typedef struct {
    logic signed [15:0] cur0;
    bit                 chg;
    logic signed [15:0] cur_chg;
    int                 vadd;
    logic [6:0]         mask;
    int                 withhold;
    int                 dly;
    int                 ovr_at;
    logic [6:0]         exp_sp;
    int                 exp_lat;
    bit                 exp_to;
    bit                 exp_ov;
    logic signed [15:0] exp_v0;
    logic signed [15:0] exp_cur0;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // core responder: answers r_dly cycles after core_start unless the index is withheld
  int                  r_vadd = 0;
  logic [6:0]          r_mask = '0;
  int                  r_withhold = -1;
  int                  r_dly = 1;
  int                  pend = 0;
  bit                  waiting = 1'b0;
  int                  unstable = 0;
  logic signed [W-1:0] lat_v, lat_u, lat_cur;
  int                  lat_idx = 0;
  int                  log_idx[$];
  logic signed [W-1:0] log_v[$], log_u[$], log_cur[$];

  always @(negedge clk) begin
    core_done = 1'b0;
    if (reset) begin
      pend    = 0;
      waiting = 1'b0;
    end else begin
      if (waiting && (core_v !== lat_v || core_u !== lat_u || core_current !== lat_cur))
        unstable++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done   = 1'b1;
          core_v_next = 16'(lat_v + r_vadd);
          core_u_next = lat_u + 16'sd8;
          core_spike  = r_mask[lat_idx];
          waiting     = 1'b0;
        end
      end
      if (core_start) begin
        lat_v   = core_v;
        lat_u   = core_u;
        lat_cur = core_current;
        lat_idx = int'(active_idx);
        log_idx.push_back(lat_idx);
        log_v.push_back(core_v);
        log_u.push_back(core_u);
        log_cur.push_back(core_current);
        if (lat_idx != r_withhold) begin
          pend    = r_dly;
          waiting = 1'b1;
        end
      end
    end
  end

  logic signed [W-1:0] v_model [N];
  logic signed [W-1:0] u_model [N];
  int                  refr    [N];

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      v_model[i] = -16'sd16640;
      u_model[i] = -16'sd3328;
      refr[i]    = 0;
    end
  endtask

  function automatic logic signed [W-1:0] pat(input int i, input logic signed [W-1:0] c0);
    if (i == 0) return c0;
    return 16'(i * 500 - 700);
  endfunction

  function automatic logic signed [W-1:0] exp_cur(input int i, input logic signed [W-1:0] c0);
`ifdef REFRACTORY_EN
    if (refr[i] != 0) return '0;
`endif
    return pat(i, c0);
  endfunction

  task automatic run_frame(input vec_t t, input string nm);
    int start, n, lat, bad, extra, busy_bad;
    bit got;
    logic [N-1:0] sp;
    r_vadd = t.vadd; r_mask = t.mask; r_withhold = t.withhold; r_dly = t.dly;
    log_idx.delete(); log_v.delete(); log_u.delete(); log_cur.delete();
    for (int i = 0; i < N; i++) current_flat[i*W +: W] = pat(i, t.cur0);
    got = 1'b0; lat = -1; sp = '0;
    @(negedge clk);
    frame_start = 1'b1;
    start = cyc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n = cyc - start;
      frame_start = (t.ovr_at == n);
      if (t.chg && n == 5) current_flat[0 +: W] = t.cur_chg;
      if (spikes_valid) begin
        got = 1'b1; lat = n; sp = spikes;
        break;
      end
    end
    frame_start = 1'b0;
    check({nm, ".done"}, got, 1);
    check({nm, ".latency"}, lat, t.exp_lat);
    check({nm, ".spikes"}, sp, t.exp_sp);
    check({nm, ".err_timeout"}, err_timeout, t.exp_to);
    check({nm, ".err_overrun"}, err_overrun, t.exp_ov);
    check({nm, ".issues"}, log_idx.size(), N);
    if (log_idx.size() > 0) begin
      check({nm, ".v0"}, log_v[0], t.exp_v0);
      check({nm, ".cur0"}, log_cur[0], t.exp_cur0);
    end
    bad = 0;
    for (int k = 0; k < log_idx.size(); k++) begin
      if (log_idx[k] != k) bad++;
      else if (log_v[k] !== v_model[k] || log_u[k] !== u_model[k] ||
               log_cur[k] !== exp_cur(k, t.cur0)) bad++;
    end
    check({nm, ".operands"}, bad, 0);
    check({nm, ".stable"}, unstable, 0);
    extra = 0; busy_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (spikes_valid) extra++;
      if (busy) busy_bad++;
    end
    check({nm, ".single_valid"}, extra, 0);
    check({nm, ".idle_after"}, busy_bad, 0);
    for (int k = 0; k < N; k++) begin
      if (k != t.withhold) begin
        v_model[k] = 16'(v_model[k] + t.vadd);
        u_model[k] = u_model[k] + 16'sd8;
        if (t.mask[k])      refr[k] = 3;
        else if (refr[k] > 0) refr[k]--;
      end else if (refr[k] > 0) refr[k]--;
    end
  endtask

  vec_t tbl [7];

  initial begin
    int start, extra;
    tbl[0] = '{16'sd1024, 1'b0, 16'sd0,    0,   7'b0000000, -1, 1,  -1, 7'b0000000, 24,  1'b0, 1'b0, -16'sd16640, 16'sd1024};
    tbl[1] = '{16'sd1024, 1'b0, 16'sd0,    256, 7'b0000100, -1, 1,  -1, 7'b0000100, 24,  1'b0, 1'b0, -16'sd16640, 16'sd1024};
    tbl[2] = '{16'sd1024, 1'b1, 16'sd3072, 0,   7'b0000000, -1, 1,  -1, 7'b0000000, 24,  1'b0, 1'b0, -16'sd16384, 16'sd1024};
    tbl[3] = '{16'sd3072, 1'b0, 16'sd0,    256, 7'b0100000, -1, 15, -1, 7'b0100000, 122, 1'b0, 1'b0, -16'sd16384, 16'sd3072};
    tbl[4] = '{16'sd3072, 1'b0, 16'sd0,    256, 7'b1001010, 3,  1,  -1, 7'b1000010, 38,  1'b1, 1'b0, -16'sd16128, 16'sd3072};
    tbl[5] = '{16'sd3072, 1'b0, 16'sd0,    0,   7'b0000000, -1, 1,  5,  7'b0000000, 24,  1'b1, 1'b1, -16'sd15872, 16'sd3072};
    tbl[6] = '{16'sd1024, 1'b0, 16'sd0,    0,   7'b0000000, -1, 1,  -1, 7'b0000000, 24,  1'b0, 1'b0, -16'sd16640, 16'sd1024};
    reset_model();

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.core_start", core_start, 0);
    check("rst.spikes_valid", spikes_valid, 0);
    check("rst.spikes", spikes, 0);
    check("rst.active_idx", active_idx, 0);
    check("rst.errs", {err_overrun, err_timeout}, 0);
    check("rst.core_v", core_v, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_frame(tbl[r], $sformatf("vec%0d", r));

    // reset part way through a frame: nothing published, everything restored
    r_vadd = 256; r_mask = 7'b1111111; r_withhold = -1; r_dly = 1;
    extra = 0;
    frame_start = 1'b1;
    start = cyc;
    while (cyc - start < 10) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (spikes_valid) extra++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst.busy", busy, 0);
    check("midrst.spikes", spikes, 0);
    check("midrst.active_idx", active_idx, 0);
    check("midrst.errs", {err_overrun, err_timeout}, 0);
    check("midrst.core_start", core_start, 0);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (spikes_valid) extra++;
    end
    check("midrst.no_publish", extra, 0);
    check("midrst.idle", busy, 0);
    reset_model();
    run_frame(tbl[6], "post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
